// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing one registered Common Data Bus among
// ALU, MULT and LSU results, with one holding slot per requester.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W = `ROB_TAG_LEN,
  parameter int DATA_W = `XLEN,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [IDX_W-1:0]          cdb_src,
  output logic [NUM_REQ-1:0]        pending
);
  localparam logic [IDX_W:0] L_N = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W:0] L_ONE = (IDX_W+1)'(1);
  logic [NUM_REQ-1:0] r_hold_vld;
  logic [TAG_W-1:0]   r_hold_tag [NUM_REQ];
  logic [DATA_W-1:0]  r_hold_val [NUM_REQ];
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_value;
  logic [IDX_W-1:0]   r_cdb_src;
  logic [NUM_REQ-1:0] w_rot, w_grant, w_acc;
  logic [IDX_W:0]     w_off, w_sum, w_inc;
  logic [IDX_W-1:0]   w_win, w_nxt;
  logic               w_any;
  // Rotate occupancy so bit 0 is rr_ptr; the lowest set bit is the winner's offset.
  always_comb begin
    w_rot = NUM_REQ'({r_hold_vld, r_hold_vld} >> r_rr_ptr);
    w_off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) if (w_rot[i]) w_off = i[IDX_W:0];
    w_sum = {1'b0, r_rr_ptr} + w_off;
    w_win = (w_sum >= L_N) ? IDX_W'(w_sum - L_N) : w_sum[IDX_W-1:0];
    w_inc = {1'b0, w_win} + L_ONE;
    w_nxt = (w_inc == L_N) ? '0 : w_inc[IDX_W-1:0];
    w_any = |r_hold_vld;
    w_grant = w_any ? (NUM_REQ'(1) << w_win) : '0;
    req_ready = {NUM_REQ{~squash}} & (~r_hold_vld | w_grant);
    w_acc = req_valid & req_ready;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_vld <= '0;
      r_rr_ptr <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag <= '0;
      r_cdb_value <= '0;
      r_cdb_src <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold_tag[i] <= '0;
        r_hold_val[i] <= '0;
      end
    end else if (squash) begin
      r_hold_vld <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_tag <= r_hold_tag[w_win];
        r_cdb_value <= r_hold_val[w_win];
        r_cdb_src <= w_win;
        r_rr_ptr <= w_nxt;
      end
      // Tag 0 completes the handshake but is dropped rather than stored.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_acc[i] && req_tag[i*TAG_W +: TAG_W] != '0) begin
          r_hold_vld[i] <= 1'b1;
          r_hold_tag[i] <= req_tag[i*TAG_W +: TAG_W];
          r_hold_val[i] <= req_value[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_hold_vld[i] <= 1'b0;
        end
      end
    end
  end
  assign cdb_valid = r_cdb_valid;
  assign cdb_tag = r_cdb_tag;
  assign cdb_value = r_cdb_value;
  assign cdb_src = r_cdb_src;
  assign pending = r_hold_vld;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios for cdb_arbiter; inputs change on the
// falling edge and outputs are sampled there, between rising edges.
module tb_cdb_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [17:0] req_tag = '0;
  logic [95:0] req_value = '0;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;
  logic [2:0]  pending;
  int n_checks = 0;
  int n_fail = 0;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_src(cdb_src), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [2:0] v, input logic [5:0] t0, t1, t2,
                       input logic [31:0] d0, d1, d2);
    req_valid = v;
    req_tag = {t2, t1, t0};
    req_value = {d2, d1, d0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src, pending} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b tag=%0d val=%h src=%0d pend=%b want all zero",
               cdb_valid, cdb_tag, cdb_value, cdb_src, pending);
    end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 111", req_ready);
    end
  endtask

  task automatic test_contention(input int start);
    logic [5:0]  et;
    logic [31:0] ev;
    logic [1:0]  es;
    @(negedge clock);
    drive(3'b111, 6'd1, 6'd2, 6'd3, 32'd100, 32'd200, 32'd300);
    #1;
    n_checks++;
    if (req_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL contention_ready: got %b want 111", req_ready);
    end
    @(negedge clock);
    drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if ({pending, cdb_valid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL contention_fill: got pend=%b v=%0b want pend=111 v=0", pending, cdb_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      es = 2'((start + k) % 3);
      et = 6'(es) + 6'd1;
      ev = 32'(et) * 32'd100;
      n_checks++;
      if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, et, ev, es}) begin
        n_fail++;
        $display("FAIL contention_order%0d_%0d: got v=%0b tag=%0d val=%0d src=%0d want v=1 tag=%0d val=%0d src=%0d",
                 start, k, cdb_valid, cdb_tag, cdb_value, cdb_src, et, ev, es);
      end
    end
    @(negedge clock);
    n_checks++;
    if ({cdb_valid, pending} !== 4'b0000) begin
      n_fail++;
      $display("FAIL contention_drain: got v=%0b pend=%b want v=0 pend=000", cdb_valid, pending);
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    drive(3'b001, 6'd5, 6'd0, 6'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    #1;
    n_checks++;
    if (req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %0b want 1", req_ready[0]);
    end
    @(negedge clock);
    drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if ({cdb_valid, pending} !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_latency: got v=%0b pend=%b want v=0 pend=001", cdb_valid, pending);
    end
    @(negedge clock);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, 6'd5, 32'hDEADBEEF, 2'd0}) begin
      n_fail++;
      $display("FAIL single_bcast: got v=%0b tag=%0d val=%h src=%0d want v=1 tag=5 val=deadbeef src=0",
               cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    @(negedge clock);
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_once: got v=%0b want 0", cdb_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (i < 4) drive(3'b010, 6'd0, 6'(4 + i), 6'd0, 32'd0, 32'(1000 + i), 32'd0);
      else drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
      #1;
      if (i < 4) begin
        n_checks++;
        if (req_ready[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready%0d: got %0b want 1", i, req_ready[1]);
        end
      end
      if (i >= 2 && i < 6) begin
        n_checks++;
        if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, 6'(i + 2), 32'(1000 + i - 2), 2'd1}) begin
          n_fail++;
          $display("FAIL b2b_bcast%0d: got v=%0b tag=%0d val=%0d src=%0d want v=1 tag=%0d val=%0d src=1",
                   i, cdb_valid, cdb_tag, cdb_value, cdb_src, i + 2, 1000 + i - 2);
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({cdb_valid, pending} !== 4'b0000) begin
          n_fail++;
          $display("FAIL b2b_end: got v=%0b pend=%b want v=0 pend=000", cdb_valid, pending);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    drive(3'b101, 6'd8, 6'd0, 6'd9, 32'h80, 32'd0, 32'h90);
    @(negedge clock);
    drive(3'b001, 6'd10, 6'd0, 6'd0, 32'hA0, 32'd0, 32'd0);
    #1;
    n_checks++;
    if ({req_ready[0], pending} !== 4'b0101) begin
      n_fail++;
      $display("FAIL bp_stall: got rdy0=%0b pend=%b want rdy0=0 pend=101", req_ready[0], pending);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src, req_ready[0]} !== {1'b1, 6'd9, 32'h90, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_first: got v=%0b tag=%0d val=%h src=%0d rdy0=%0b want v=1 tag=9 val=90 src=2 rdy0=1",
               cdb_valid, cdb_tag, cdb_value, cdb_src, req_ready[0]);
    end
    @(negedge clock);
    drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src, pending} !== {1'b1, 6'd8, 32'h80, 2'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL bp_held: got v=%0b tag=%0d val=%h src=%0d pend=%b want v=1 tag=8 val=80 src=0 pend=001",
               cdb_valid, cdb_tag, cdb_value, cdb_src, pending);
    end
    @(negedge clock);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src, pending} !== {1'b1, 6'd10, 32'hA0, 2'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_second: got v=%0b tag=%0d val=%h src=%0d pend=%b want v=1 tag=10 val=a0 src=0 pend=000",
               cdb_valid, cdb_tag, cdb_value, cdb_src, pending);
    end
    @(negedge clock);
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_nodup: got v=%0b want 0", cdb_valid);
    end
  endtask

  task automatic test_tag_zero();
    @(negedge clock);
    drive(3'b100, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'h1234);
    #1;
    n_checks++;
    if (req_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL tag0_ready: got %0b want 1", req_ready[2]);
    end
    @(negedge clock);
    drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if ({pending, cdb_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL tag0_pending: got pend=%b v=%0b want pend=000 v=0", pending, cdb_valid);
    end
    @(negedge clock);
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tag0_nobcast: got v=%0b want 0", cdb_valid);
    end
  endtask

  task automatic test_squash_reset();
    @(negedge clock);
    drive(3'b111, 6'd11, 6'd12, 6'd13, 32'd11, 32'd12, 32'd13);
    @(negedge clock);
    drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    squash = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, pending} !== 6'b000111) begin
      n_fail++;
      $display("FAIL squash_ready: got rdy=%b pend=%b want rdy=000 pend=111", req_ready, pending);
    end
    @(negedge clock);
    squash = 1'b0;
    n_checks++;
    if ({pending, cdb_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL squash_clear: got pend=%b v=%0b want pend=000 v=0", pending, cdb_valid);
    end
    drive(3'b111, 6'd11, 6'd12, 6'd13, 32'd11, 32'd12, 32'd13);
    @(negedge clock);
    drive(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, 6'd12, 2'd1}) begin
      n_fail++;
      $display("FAIL squash_ptr: got v=%0b tag=%0d src=%0d want v=1 tag=12 src=1",
               cdb_valid, cdb_tag, cdb_src);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src, pending} !== 44'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b tag=%0d val=%h src=%0d pend=%b want all zero",
               cdb_valid, cdb_tag, cdb_value, cdb_src, pending);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({req_ready, cdb_valid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%0b want rdy=111 v=0", req_ready, cdb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_contention(0);
    test_single();
    test_contention(1);
    test_back_to_back();
    test_backpressure();
    test_tag_zero();
    test_squash_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
